// File: rtl/sensor_request.sv
// sensor_request: input-side conditioner for the east/west vehicle sensor.
// A two-flop synchronizer feeds a debouncer whose stable level drives a
// small request machine. The machine asserts go_request toward the
// intersection FSM until that FSM reports the east/west approach is served.
// It also tracks how many whole seconds the current request has waited.
module sensor_request #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20,
    parameter int MAX_WAIT        = 8
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       sensor_in,
    input  logic       tick_1s,
    input  logic [2:0] fsm_state,
    output logic       go_request,
    output logic       sensor_level,
    output logic [3:0] wait_secs,
    output logic       starved
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        SERVED  = 2'd2
    } req_state_t;

    // Last count value before a new level is accepted.
    localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0]       MAX_WAIT_W = 4'(MAX_WAIT);

    logic             sync1_reg;
    logic             sync2_reg;
    logic [CNT_W-1:0] db_cnt_reg;
    logic             lvl_reg;

    req_state_t       state_reg;
    logic             go_request_reg;
    logic [3:0]       wait_secs_reg;
    logic             starved_reg;

    logic             served;
    logic [3:0]       wait_inc;
    logic [3:0]       wait_next;

    // East/west left (3) and east/west green (4) count as service; every
    // other light code means the side road is still waiting.
    assign served = (fsm_state == 3'd3) || (fsm_state == 3'd4);

    // Saturating one-second increment of the pending time.
    always_comb begin
        wait_inc  = wait_secs_reg;
        wait_next = wait_secs_reg;
        if (wait_secs_reg != 4'hF) begin
            wait_inc = wait_secs_reg + 4'd1;
        end
        if (tick_1s) begin
            wait_next = wait_inc;
        end
    end

    // Two-flop synchronizer for the asynchronous sensor line.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
        end else begin
            sync1_reg <= sensor_in;
            sync2_reg <= sync1_reg;
        end
    end

    // Debouncer: a new level must persist for DEBOUNCE_CYCLES consecutive
    // samples; any return to the stable level restarts the count.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            db_cnt_reg <= '0;
            lvl_reg    <= 1'b0;
        end else if (sync2_reg == lvl_reg) begin
            db_cnt_reg <= '0;
        end else if (db_cnt_reg == DB_LAST) begin
            lvl_reg    <= sync2_reg;
            db_cnt_reg <= '0;
        end else begin
            db_cnt_reg <= db_cnt_reg + CNT_W'(1);
        end
    end

    // Request machine with registered outputs; each output is written on
    // the same edge as the state it belongs to, so nothing is combinational.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_reg      <= IDLE;
            go_request_reg <= 1'b0;
            wait_secs_reg  <= 4'd0;
            starved_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    wait_secs_reg <= 4'd0;
                    starved_reg   <= 1'b0;
                    if (lvl_reg && !served) begin
                        state_reg      <= PENDING;
                        go_request_reg <= 1'b1;
                    end else begin
                        go_request_reg <= 1'b0;
                    end
                end
                PENDING: begin
                    if (served) begin
                        // Service wins over a tick or a departure in the
                        // same cycle; the wait count is frozen as-is.
                        state_reg      <= SERVED;
                        go_request_reg <= 1'b0;
                        starved_reg    <= 1'b0;
                    end else if (!lvl_reg) begin
                        state_reg      <= IDLE;
                        go_request_reg <= 1'b0;
                        wait_secs_reg  <= 4'd0;
                        starved_reg    <= 1'b0;
                    end else begin
                        go_request_reg <= 1'b1;
                        wait_secs_reg  <= wait_next;
                        starved_reg    <= (wait_next >= MAX_WAIT_W);
                    end
                end
                SERVED: begin
                    go_request_reg <= 1'b0;
                    starved_reg    <= 1'b0;
                    if (!served) begin
                        // A car still present re-requests from IDLE next.
                        state_reg     <= IDLE;
                        wait_secs_reg <= 4'd0;
                    end
                end
                default: begin
                    state_reg      <= IDLE;
                    go_request_reg <= 1'b0;
                    wait_secs_reg  <= 4'd0;
                    starved_reg    <= 1'b0;
                end
            endcase
        end
    end

    assign go_request   = go_request_reg;
    assign sensor_level = lvl_reg;
    assign wait_secs    = wait_secs_reg;
    assign starved      = starved_reg;

endmodule

// File: tb/tb_sensor_request.sv
// tb_sensor_request: scenario-driven bench for sensor_request using a
// queue of expected output vectors {go, level, wait[3:0], starved}.
module tb_sensor_request;

    logic       CLOCK_50;
    logic       resetn;
    logic       sensor_in;
    logic       tick_1s;
    logic [2:0] fsm_state;
    logic       go_request;
    logic       sensor_level;
    logic [3:0] wait_secs;
    logic       starved;

    logic [6:0] obs;
    logic [6:0] sb[$];
    logic [6:0] exp_v;
    int         checks;
    int         errors;

    sensor_request #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3),
        .MAX_WAIT       (3)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .resetn      (resetn),
        .sensor_in   (sensor_in),
        .tick_1s     (tick_1s),
        .fsm_state   (fsm_state),
        .go_request  (go_request),
        .sensor_level(sensor_level),
        .wait_secs   (wait_secs),
        .starved     (starved)
    );

    assign obs = {go_request, sensor_level, wait_secs, starved};

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    // Advance one rising edge and settle 1 ns past it.
    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic test_reset();
        resetn    = 1'b1;
        sensor_in = 1'b0;
        tick_1s   = 1'b0;
        fsm_state = 3'd0;
        #3 resetn = 1'b0;
        #1;
        sb.push_back(7'b0);
        exp_v = sb.pop_front();
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL reset_async: got %b expected %b", obs, exp_v);
        end else begin
            $display("check reset_async ok: outputs %b", obs);
        end
        step();
        step();
        resetn = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            sb.push_back(7'b0);
            step();
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL reset_idle edge %0d: got %b expected %b", k, obs, exp_v);
            end else begin
                $display("check reset_idle edge %0d ok: outputs %b", k, obs);
            end
        end
    endtask

    task automatic test_bounce();
        logic [11:0] pat;
        pat = 12'b000000_110_111;  // applied LSB first
        for (int i = 0; i < 12; i++) begin
            sensor_in = pat[i];
            sb.push_back(7'b0);
            step();
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL bounce cycle %0d: got %b expected %b", i, obs, exp_v);
            end else begin
                $display("check bounce cycle %0d ok: outputs %b", i, obs);
            end
        end
    endtask

    // Raise the sensor and expect level at edge 6, request at edge 7.
    task automatic test_arrival(input string tag);
        sensor_in = 1'b1;
        fsm_state = 3'd0;
        for (int k = 1; k <= 7; k++) begin
            sb.push_back({(k >= 7), (k >= 6), 4'd0, 1'b0});
            step();
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL %s edge %0d: got go=%b lvl=%b wait=%0d starved=%b expected go=%b lvl=%b wait=%0d starved=%b",
                         tag, k, obs[6], obs[5], obs[4:1], obs[0], exp_v[6], exp_v[5], exp_v[4:1], exp_v[0]);
            end else begin
                $display("check %s edge %0d ok: outputs %b", tag, k, obs);
            end
        end
    endtask

    task automatic test_service();
        fsm_state = 3'd4;
        for (int i = 0; i <= 4; i++) begin
            if (i == 3) fsm_state = 3'd0;
            sb.push_back({(i == 4), 1'b1, 4'd0, 1'b0});
            step();
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL service step %0d: got go=%b wait=%0d expected go=%b wait=%0d",
                         i, obs[6], obs[4:1], exp_v[6], exp_v[4:1]);
            end else begin
                $display("check service step %0d ok: outputs %b", i, obs);
            end
        end
    endtask

    task automatic test_priority_a();
        tick_1s = 1'b1;
        sb.push_back({1'b1, 1'b1, 4'd1, 1'b0});
        step();
        exp_v = sb.pop_front();
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL priority_pre_tick: got %b expected %b", obs, exp_v);
        end else begin
            $display("check priority_pre_tick ok: outputs %b", obs);
        end
        // Tick, service and departure all in the same cycle.
        tick_1s   = 1'b1;
        fsm_state = 3'd3;
        sensor_in = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            if (k == 7) fsm_state = 3'd0;
            if (k == 7) sb.push_back(7'b0);
            else        sb.push_back({1'b0, (k < 6), 4'd1, 1'b0});
            step();
            tick_1s = 1'b0;
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL priority_a edge %0d: got go=%b lvl=%b wait=%0d starved=%b expected go=%b lvl=%b wait=%0d starved=%b",
                         k, obs[6], obs[5], obs[4:1], obs[0], exp_v[6], exp_v[5], exp_v[4:1], exp_v[0]);
            end else begin
                $display("check priority_a edge %0d ok: outputs %b", k, obs);
            end
        end
    endtask

    task automatic test_starvation();
        int         n;
        logic [3:0] w;
        n = 0;
        for (int i = 0; i < 46; i++) begin
            tick_1s = (i % 2 == 0);
            if (tick_1s) n++;
            w = (n > 15) ? 4'd15 : 4'(n);
            sb.push_back({1'b1, 1'b1, w, (w >= 4'd3)});
            step();
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL starvation cycle %0d ticks %0d: got wait=%0d starved=%b go=%b expected wait=%0d starved=%b go=%b",
                         i, n, obs[4:1], obs[0], obs[6], exp_v[4:1], exp_v[0], exp_v[6]);
            end else begin
                $display("check starvation cycle %0d ok: wait=%0d starved=%b", i, obs[4:1], obs[0]);
            end
        end
        tick_1s = 1'b0;
    endtask

    task automatic test_departure();
        sensor_in = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            if (k == 7) sb.push_back(7'b0);
            else        sb.push_back({1'b1, (k < 6), 4'd15, 1'b1});
            step();
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL departure edge %0d: got %b expected %b", k, obs, exp_v);
            end else begin
                $display("check departure edge %0d ok: outputs %b", k, obs);
            end
        end
    endtask

    task automatic test_reset_mid();
        test_arrival("pre_reset_arrival");
        #2 resetn = 1'b0;
        #1;
        sb.push_back(7'b0);
        exp_v = sb.pop_front();
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL reset_mid: got %b expected %b", obs, exp_v);
        end else begin
            $display("check reset_mid ok: outputs %b", obs);
        end
        step();
        resetn = 1'b1;
        test_arrival("post_reset_arrival");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_bounce();
        test_arrival("clean_arrival");
        test_service();
        test_priority_a();
        test_arrival("starve_arrival");
        test_starvation();
        test_departure();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sensor_request.md
# sensor_request

Input-side conditioner for the side-road (east/west) vehicle sensor. It synchronizes and debounces the raw GPIO sensor line and runs a small request state machine. The machine raises a registered request toward the intersection FSM's go input and holds it until the FSM reports that the east/west approach is being served. It sits between the GPIO pin and the FSM, mirroring the light decoder on the output side, and consumes the current 3-bit light-state code plus the 1-second tick from the counter chain.

## Interface
- DEBOUNCE_CYCLES, 500000: clock cycles the synchronized input must stay at a new level before it is accepted (10 ms at 50 MHz); must be ≥ 2.
- CNT_W, 20: debounce counter width; must hold DEBOUNCE_CYCLES-1.
- MAX_WAIT, 8: seconds pending before `starved` asserts; range 1..15.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- sensor_in  in  1  raw sensor line from GPIO. Asynchronous and may bounce.
- tick_1s  in  1  one-cycle pulse, once per second, synchronous to CLOCK_50.
- fsm_state  in  3  current light-state code, 0..7, as produced by the intersection FSM.
- go_request  out  1  registered request to the FSM (goControl[0]).
- sensor_level  out  1  debounced sensor level, for LED display.
- wait_secs  out  4  whole seconds the current request has been pending; saturates at 15.
- starved  out  1  high while pending and wait_secs ≥ MAX_WAIT.

## Operation
- Synchronizer: two flops, sync1 then sync2, with sensor_in feeding sync1.
- Debounce: a counter `db_cnt` and a stable level `lvl`, which drives sensor_level.
  - If sync2 equals lvl, db_cnt clears to 0.
  - Otherwise, if db_cnt equals DEBOUNCE_CYCLES-1, lvl is set to sync2 and db_cnt clears to 0.
  - Otherwise, db_cnt increments.
  - A level change that returns before acceptance produces no output change.
- served is true when fsm_state is 3'd3 (E/W left) or 3'd4 (E/W green). It is combinational from fsm_state.
- Request FSM states:
  - IDLE: go_request = 0, wait_secs = 0. Move to PENDING when lvl = 1 and served is false.
  - PENDING: go_request = 1.
    - On tick_1s, wait_secs increments, saturating at 15.
    - If served is true, move to SERVED. This takes priority over every other event in the same cycle.
    - Otherwise, if lvl = 0 (car left), move to IDLE.
  - SERVED: go_request = 0. wait_secs holds its last value. Move to IDLE when served is false.
- A car still present when service ends re-enters PENDING from IDLE on the next cycle. There is no lost request.
- tick_1s in IDLE or SERVED has no effect.
- starved = (state == PENDING) && (wait_secs ≥ MAX_WAIT). It is registered.
- fsm_state codes other than 3 and 4 are treated as not served. No code is illegal.

## Timing
- Reset, asynchronous and taking effect immediately:
  - sync1, sync2, lvl, db_cnt = 0.
  - State = IDLE.
  - go_request, sensor_level, wait_secs, starved = 0.
- Reset asserted mid-request drops go_request on assertion. After release, a car that is still present must re-debounce before requesting again.
- Latency from a clean raw edge:
  - sync2 follows 2 rising edges after the raw change.
  - sensor_level changes DEBOUNCE_CYCLES edges after that, for DEBOUNCE_CYCLES + 2 edges total.
  - go_request asserts 1 edge after sensor_level rises, when not served.
- served rising while PENDING: go_request falls on the next edge.
- served falling while SERVED: the state reaches IDLE on the next edge. If lvl = 1, go_request rises on the following edge, 2 edges after served falls.
- wait_secs updates on the edge where tick_1s is high. starved updates on the same edge as the wait_secs value it reflects.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
Use DEBOUNCE_CYCLES = 4 and MAX_WAIT = 3 unless noted.
- Clean arrival: hold fsm_state = 0 and drive sensor_in 0→1. Required: sensor_level = 1 after 6 edges and go_request = 1 after 7 edges. wait_secs = 0 and starved = 0.
- Bounce rejection: drive sensor_in high for 3 cycles, low, then high for 2 cycles. Required: sensor_level and go_request stay 0 throughout.
- Service handshake: while pending, set fsm_state = 4. Required: go_request = 0 on the next edge. Return fsm_state to 0 with the sensor still high. Required: go_request = 1 two edges later and wait_secs = 0.
- Starvation: pending with fsm_state = 0, apply 3 tick_1s pulses. Required: wait_secs = 3 and starved = 1. Apply 20 more ticks. Required: wait_secs = 15, saturated.
- Priority and departure:
  - Case A: tick_1s, fsm_state = 3 and a sensor drop all in the same cycle. Required: the state becomes SERVED and wait_secs is unchanged.
  - Case B: a separate run where the car leaves while pending. Required: go_request falls one edge after sensor_level falls.
- Reset mid-request: assert resetn = 0 while go_request = 1. Required: all outputs read 0 immediately. After release with the sensor held high, go_request = 1 after 7 edges.
